i_mem_fill_ctrl: RTL and testbench

- Miss-fill engine directly downstream of the instruction cache.
- Takes the cache's registered line-fill request (address plus valid pulse) and issues four 32-bit word reads to the instruction memory over a ready/valid port, with up to MAX_OUTSTANDING reads in flight.
- Assembles the returned words into one 128-bit cache line and returns it to the cache as a single-cycle response with the requested address.

---
 rtl/i_mem_fill_ctrl.sv | 95 +++++++++
 tb/tb_i_mem_fill_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i_mem_fill_ctrl.sv
// i_mem_fill_ctrl: I-cache miss-fill engine that reads four words and returns one 128-bit line.
// Optional macro IFU_FILL_CRITICAL_WORD_FIRST_EN: start the beat sequence at the missed word and wrap.
module i_mem_fill_ctrl #(
  parameter int CL_WORDS        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fill_req_valid,
  input  logic [31:0]             fill_req_address,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_address,
  output logic [32*CL_WORDS-1:0]  rsp_line,
  output logic                    busy,
  output logic                    req_dropped,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_address,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [31:0]             mem_rsp_data
);
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  localparam logic [2:0] MAX_O = 3'(MAX_OUTSTANDING);
  localparam logic [2:0] BEATS = 3'(CL_WORDS);
  state_t                  state_q, state_d;
  logic [31:0]             addr_q, addr_d;
  logic [32*CL_WORDS-1:0]  line_q, line_d;
  logic [2:0]              issued_q, issued_d, returned_q, returned_d, outst_q, outst_d;
  logic [1:0]              start_word, issue_word, ret_word;
  logic                    accept, ret;
`ifdef IFU_FILL_CRITICAL_WORD_FIRST_EN
  assign start_word = addr_q[3:2];
`else
  assign start_word = 2'd0;
`endif
  // 2-bit word indices wrap inside the line, so the base never carries into bit 4
  assign issue_word      = start_word + issued_q[1:0];
  assign ret_word        = start_word + returned_q[1:0];
  assign mem_req_valid   = state_q == FETCH && issued_q < BEATS && outst_q < MAX_O;
  assign mem_req_address = {addr_q[31:4], issue_word, 2'b00};
  assign accept          = mem_req_valid && mem_req_ready;
  assign ret             = mem_rsp_valid && outst_q != 3'd0;
  assign rsp_valid       = state_q == RESP;
  assign busy            = state_q != IDLE;
  assign req_dropped     = fill_req_valid && busy;
  assign rsp_address     = addr_q;
  assign rsp_line        = line_q;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    line_d     = line_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;
    case (state_q)
      IDLE: if (fill_req_valid) begin
        state_d    = FETCH;
        addr_d     = fill_req_address;
        issued_d   = 3'd0;
        returned_d = 3'd0;
      end
      FETCH: begin
        issued_d = accept ? issued_q + 3'd1 : issued_q;
        outst_d  = outst_q + 3'(accept) - 3'(ret);
        if (ret) begin
          line_d[{ret_word, 5'd0} +: 32] = mem_rsp_data;
          returned_d                     = returned_q + 3'd1;
          state_d                        = returned_q == BEATS - 3'd1 ? RESP : FETCH;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      line_q     <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
    end
  end
  a_outst_bound: assert property (@(posedge clk) disable iff (!rst) outst_q <= MAX_O);
  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    mem_req_valid && !mem_req_ready |=> mem_req_valid && $stable(mem_req_address));
endmodule

// File: tb/tb_i_mem_fill_ctrl.sv
// tb_i_mem_fill_ctrl: transaction-level model of the fill engine with an in-order latency memory.
module tb_i_mem_fill_ctrl;
  localparam int MAXO = 2;
  logic         clk = 1'b0, rst = 1'b0;
  logic         fill_req_valid = 1'b0;
  logic [31:0]  fill_req_address = '0;
  logic         rsp_valid, busy, req_dropped, mem_req_valid;
  logic [31:0]  rsp_address, mem_req_address;
  logic [127:0] rsp_line;
  logic         mem_req_ready = 1'b1, mem_rsp_valid = 1'b0;
  logic [31:0]  mem_rsp_data = '0;
  int compared = 0, mismatched = 0;
  int cyc = 0, lat = 1, acc_total = 0, stall_after = -1, stall_left = 0;
  int due_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] acc_log[$];
  bit active = 0, prev_stall = 0;
  int issued = 0, returned = 0, inflight = 0, max_inflight = 0;
  int req_cyc = 0, rsp_cnt = 0, drop_cnt = 0, last_lat = 0;
  logic [31:0]  m_addr = '0, last_addr = '0, seen_addr = '0, prev_addr = '0;
  logic [127:0] last_line = '0, seen_line = '0;
  logic [31:0]  exp_req[4];
  logic [31:0]  order[4];

  always #5 clk = ~clk;

  i_mem_fill_ctrl #(.CL_WORDS(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .fill_req_valid(fill_req_valid), .fill_req_address(fill_req_address),
    .rsp_valid(rsp_valid), .rsp_address(rsp_address), .rsp_line(rsp_line),
    .busy(busy), .req_dropped(req_dropped),
    .mem_req_valid(mem_req_valid), .mem_req_address(mem_req_address),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory returns data equal to the word address, in order, lat cycles after acceptance
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = {a[31:4], 4'd0} + 32'(4 * w);
    return l;
  endfunction

  initial forever begin
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) begin
      due_q.push_back(cyc + lat);
      pend_q.push_back(mem_req_address);
      acc_log.push_back(mem_req_address);
      acc_total++;
    end
    @(posedge clk);
    cyc++;
    #1;
    mem_rsp_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pend_q.pop_front();
      void'(due_q.pop_front());
    end
    mem_req_ready = !(stall_left > 0 && acc_total == stall_after);
    if (!mem_req_ready) stall_left--;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_req_dropped", 128'(req_dropped), 128'(0));
      chk("reset_mem_req_valid", 128'(mem_req_valid), 128'(0));
      chk("reset_rsp_line", rsp_line, 128'(0));
      chk("reset_rsp_address", 128'(rsp_address), 128'(0));
      active = 0; issued = 0; returned = 0; inflight = 0; prev_stall = 0;
      last_line = '0; last_addr = '0;
    end else begin
      automatic bit exp_rsp = active && returned == 4;
      automatic bit exp_v   = active && issued < 4 && inflight < MAXO;
      automatic int ib      = inflight;
      chk("busy", 128'(busy), 128'(active));
      chk("req_dropped", 128'(req_dropped), 128'(fill_req_valid && active));
      chk("rsp_valid", 128'(rsp_valid), 128'(exp_rsp));
      chk("mem_req_valid", 128'(mem_req_valid), 128'(exp_v));
      if (exp_v && mem_req_valid) chk("mem_req_address", 128'(mem_req_address), 128'(exp_req[issued]));
      if (prev_stall) chk("req_hold_address", 128'(mem_req_address), 128'(prev_addr));
      if (!active) begin
        chk("idle_rsp_line", rsp_line, last_line);
        chk("idle_rsp_address", 128'(rsp_address), 128'(last_addr));
      end
      if (exp_rsp && rsp_valid) begin
        chk("rsp_line", rsp_line, line_of(m_addr));
        chk("rsp_address", 128'(rsp_address), 128'(m_addr));
        seen_line = rsp_line; seen_addr = rsp_address;
        last_lat = cyc - req_cyc; rsp_cnt++;
        last_line = line_of(m_addr); last_addr = m_addr;
      end
      if (req_dropped) drop_cnt++;
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_address;
      if (!active) begin
        if (fill_req_valid) begin
          automatic int c = 0;
`ifdef IFU_FILL_CRITICAL_WORD_FIRST_EN
          c = int'(fill_req_address[3:2]);
`endif
          active = 1; issued = 0; returned = 0; inflight = 0;
          m_addr = fill_req_address; req_cyc = cyc;
          for (int k = 0; k < 4; k++)
            exp_req[k] = {fill_req_address[31:4], 4'd0} + 32'(4 * ((c + k) % 4));
        end
      end else if (exp_rsp) begin
        active = 0;
      end else begin
        if (exp_v && mem_req_ready) begin issued++; inflight++; end
        if (mem_rsp_valid && ib > 0) begin returned++; inflight--; end
        if (inflight > max_inflight) max_inflight = inflight;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] a);
    fill_req_valid = 1'b1; fill_req_address = a;
    tick();
    fill_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int budget);
    automatic int start = rsp_cnt;
    for (int i = 0; i < budget && rsp_cnt == start; i++) tick();
    chk(name, 128'(rsp_cnt - start), 128'(1));
    tick(2);
  endtask

  initial begin
    automatic int b, c0, d0, bad;
`ifdef IFU_FILL_CRITICAL_WORD_FIRST_EN
    order[0] = 32'h1238; order[1] = 32'h123C; order[2] = 32'h1230; order[3] = 32'h1234;
`else
    order[0] = 32'h1230; order[1] = 32'h1234; order[2] = 32'h1238; order[3] = 32'h123C;
`endif
    tick(3);
    rst = 1'b1;
    tick(2);
    b = acc_log.size();
    fill(32'h0000_1238);
    wait_rsp("basic_done", 30);
    chk("basic_latency", 128'(last_lat), 128'(6));
    chk("basic_line", seen_line, 128'h0000123C_00001238_00001234_00001230);
    chk("basic_address", 128'(seen_addr), 128'h1238);
    for (int k = 0; k < 4; k++) chk("basic_order", 128'(acc_log[b + k]), 128'(order[k]));
    b = acc_log.size();
    stall_after = acc_total + 2; stall_left = 3;
    fill(32'h0000_1238);
    wait_rsp("stall_done", 40);
    chk("stall_latency", 128'(last_lat), 128'(9));
    chk("stall_consumed", 128'(stall_left), 128'(0));
    chk("stall_beat2_address", 128'(acc_log[b + 2]), 128'(order[2]));
    chk("stall_line", seen_line, 128'h0000123C_00001238_00001234_00001230);
    lat = 5; max_inflight = 0;
    fill(32'h0000_3010);
    wait_rsp("outstanding_done", 80);
    chk("outstanding_max", 128'(max_inflight), 128'(2));
    chk("outstanding_line", seen_line, 128'h0000301C_00003018_00003014_00003010);
    lat = 1; c0 = rsp_cnt; d0 = drop_cnt; b = acc_log.size();
    fill(32'h0000_5000);
    tick(1);
    fill(32'h0000_2000);
    tick(3);
    fill(32'h0000_6000);
    tick(3);
    chk("drop_rsp_count", 128'(rsp_cnt - c0), 128'(1));
    chk("drop_pulses", 128'(drop_cnt - d0), 128'(2));
    chk("drop_line", seen_line, 128'h0000500C_00005008_00005004_00005000);
    bad = 0;
    for (int k = b; k < acc_log.size(); k++)
      if (acc_log[k][31:4] == 28'h200 || acc_log[k][31:4] == 28'h600) bad++;
    chk("drop_no_access", 128'(bad), 128'(0));
    lat = 5; b = acc_total;
    fill(32'h0000_3000);
    for (int i = 0; i < 40 && acc_total < b + 2; i++) tick();
    chk("rst_two_beats", 128'(acc_total - b), 128'(2));
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    c0 = rsp_cnt;
    tick(12);
    chk("rst_stale_drained", 128'(due_q.size()), 128'(0));
    chk("rst_no_rsp", 128'(rsp_cnt - c0), 128'(0));
    chk("rst_line_clear", rsp_line, 128'(0));
    lat = 1;
    fill(32'h0000_4000);
    wait_rsp("rst_refill_done", 30);
    chk("rst_refill_line", seen_line, 128'h0000400C_00004008_00004004_00004000);
    chk("rst_refill_address", 128'(seen_addr), 128'h4000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
